// File: rtl/timer_pkg.sv
// Shared types and constants for the elapsed-seconds timer.
package timer_pkg;

    localparam int unsigned SECONDS_PER_DAY = 86400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle request per low-to-high transition of a level input.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Remember last cycle's level so a held input only requests once
    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/elapsed_seconds_timer.sv
// Run/pause/clear seconds counter driven by a clock prescaler, wrapping once a day,
// with a one-shot timestamp of the first event after each clear.
module elapsed_seconds_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned MAX_SECONDS = SECONDS_PER_DAY - 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        event_in,
    output logic [31:0] total_seconds_elapsed,
    output logic        running,
    output logic        sec_tick,
    output logic        wrap,
    output logic [31:0] event_time,
    output logic        event_valid
);

    localparam int unsigned PRES_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRES_W-1:0] PRES_TC = PRES_W'(CLK_FREQ_HZ - 1);
    localparam logic [31:0] COUNT_MAX = 32'(MAX_SECONDS);

    logic start_req, stop_req, clear_req, event_req;

    state_e            state_q, state_d;
    logic [PRES_W-1:0] pres_q, pres_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       evt_q, evt_d;
    logic              evv_q, evv_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              running_q;

    rise_detect u_rise_start (.clk(clk), .resetn(resetn), .in(start),    .pulse(start_req));
    rise_detect u_rise_stop  (.clk(clk), .resetn(resetn), .in(stop),     .pulse(stop_req));
    rise_detect u_rise_clear (.clk(clk), .resetn(resetn), .in(clear),    .pulse(clear_req));
    rise_detect u_rise_event (.clk(clk), .resetn(resetn), .in(event_in), .pulse(event_req));

    // Next-state: request priority clear > stop > start, prescaler/count advance, event capture
    always_comb begin
        state_d = state_q;
        pres_d  = pres_q;
        count_d = count_q;
        evt_d   = evt_q;
        evv_d   = evv_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (clear_req) begin
            state_d = IDLE;
            pres_d  = '0;
            count_d = '0;
            evt_d   = '0;
            evv_d   = 1'b0;
        end else begin
            // Capture uses the pre-increment count
            if (event_req && !evv_q && (state_q != IDLE)) begin
                evt_d = count_q;
                evv_d = 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_req && !stop_req) begin
                        state_d = RUNNING;
                        pres_d  = '0;
                    end
                end
                RUNNING: begin
                    if (stop_req) begin
                        state_d = PAUSED;
                    end else if (pres_q == PRES_TC) begin
                        pres_d = '0;
                        tick_d = 1'b1;
                        if (count_q == COUNT_MAX) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + 32'd1;
                        end
                    end else begin
                        pres_d = pres_q + PRES_W'(1);
                    end
                end
                PAUSED: begin
                    // Prescaler is kept so a partial second resumes
                    if (start_req && !stop_req) begin
                        state_d = RUNNING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pres_q    <= '0;
            count_q   <= '0;
            evt_q     <= '0;
            evv_q     <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pres_q    <= pres_d;
            count_q   <= count_d;
            evt_q     <= evt_d;
            evv_q     <= evv_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == RUNNING);
        end
    end

    assign total_seconds_elapsed = count_q;
    assign running               = running_q;
    assign sec_tick              = tick_q;
    assign wrap                  = wrap_q;
    assign event_time            = evt_q;
    assign event_valid           = evv_q;

endmodule

// File: tb/tb_elapsed_seconds_timer.sv
// Bench for elapsed_seconds_timer: two instances (full-day and 4-second wrap) on shared stimulus,
// checked every cycle against a behavioural model plus hand-computed directed vectors.
module tb_elapsed_seconds_timer;

    localparam int unsigned F    = 4;
    localparam int unsigned MAXB = 86399;
    localparam int unsigned MAXW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, start, stop, clear, event_in;

    logic [31:0] cnt_b, evt_b, cnt_w, evt_w;
    logic        run_b, tick_b, wrap_b, evv_b;
    logic        run_w, tick_w, wrap_w, evv_w;

    elapsed_seconds_timer #(.CLK_FREQ_HZ(F), .MAX_SECONDS(MAXB)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
        .event_in(event_in), .total_seconds_elapsed(cnt_b), .running(run_b),
        .sec_tick(tick_b), .wrap(wrap_b), .event_time(evt_b), .event_valid(evv_b)
    );

    elapsed_seconds_timer #(.CLK_FREQ_HZ(F), .MAX_SECONDS(MAXW)) dut_w (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
        .event_in(event_in), .total_seconds_elapsed(cnt_w), .running(run_w),
        .sec_tick(tick_w), .wrap(wrap_w), .event_time(evt_w), .event_valid(evv_w)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0=idle 1=run 2=pause, sub = cycles into current second
    typedef struct {
        int mode;
        int sub;
        int secs;
        int et;
        bit ev;
        bit tick;
        bit wrp;
        bit ps, pp, pc, pe;
    } model_t;

    model_t mb, mw;

    function automatic model_t mstep(model_t m, int maxs, bit rst, bit s, bit p, bit c, bit e);
        model_t r;
        bit rs, rp, rc, re;
        r = m;
        if (!rst) begin
            r = '{default: 0};
            return r;
        end
        rs = s && !m.ps;
        rp = p && !m.pp;
        rc = c && !m.pc;
        re = e && !m.pe;
        r.tick = 0;
        r.wrp  = 0;
        if (rc) begin
            r.mode = 0; r.sub = 0; r.secs = 0; r.et = 0; r.ev = 0;
        end else begin
            if (re && !m.ev && m.mode != 0) begin
                r.et = m.secs;
                r.ev = 1;
            end
            if (rp) begin
                if (m.mode == 1) r.mode = 2;
            end else if (rs && m.mode != 1) begin
                if (m.mode == 0) r.sub = 0;
                r.mode = 1;
            end else if (m.mode == 1) begin
                r.sub = m.sub + 1;
                if (r.sub == int'(F)) begin
                    r.sub  = 0;
                    r.tick = 1;
                    r.secs = (m.secs + 1) % (maxs + 1);
                    r.wrp  = (r.secs == 0);
                end
            end
        end
        r.ps = s; r.pp = p; r.pc = c; r.pe = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance model on the edge, then compare both instances just after it
    task automatic cyc();
        @(posedge clk);
        mb = mstep(mb, int'(MAXB), resetn, start, stop, clear, event_in);
        mw = mstep(mw, int'(MAXW), resetn, start, stop, clear, event_in);
        #1;
        chk("b.count",   cnt_b,        32'(mb.secs));
        chk("b.running", 32'(run_b),   32'(mb.mode == 1));
        chk("b.tick",    32'(tick_b),  32'(mb.tick));
        chk("b.wrap",    32'(wrap_b),  32'(mb.wrp));
        chk("b.evtime",  evt_b,        32'(mb.et));
        chk("b.evvalid", 32'(evv_b),   32'(mb.ev));
        chk("w.count",   cnt_w,        32'(mw.secs));
        chk("w.running", 32'(run_w),   32'(mw.mode == 1));
        chk("w.tick",    32'(tick_w),  32'(mw.tick));
        chk("w.wrap",    32'(wrap_w),  32'(mw.wrp));
        chk("w.evtime",  evt_w,        32'(mw.et));
        chk("w.evvalid", 32'(evv_w),   32'(mw.ev));
    endtask

    typedef struct {
        bit s, p, c, e;
        int n;
        int cnt;
        bit run;
        int et;
        bit ev;
    } vec_t;

    vec_t tbl[$];

    initial begin
        mb = '{default: 0};
        mw = '{default: 0};
        resetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; event_in = 1'b0;
        repeat (2) cyc();
        resetn = 1'b1;

        // Reset mid-run at count 17 discards everything
        start = 1'b1; cyc(); start = 1'b0;
        repeat (68) cyc();
        chk("pre_reset_count", cnt_b, 32'd17);
        resetn = 1'b0;
        repeat (2) cyc();
        chk("rst_count",   cnt_b, 32'd0);
        chk("rst_running", 32'(run_b), 32'd0);
        chk("rst_evvalid", 32'(evv_b), 32'd0);
        chk("rst_w_count", cnt_w, 32'd0);
        resetn = 1'b1;
        repeat (20) cyc();
        chk("idle_hold_count",   cnt_b, 32'd0);
        chk("idle_hold_running", 32'(run_b), 32'd0);

        // Directed vectors: {start,stop,clear,event, cycles, count, running, event_time, event_valid}
        tbl.push_back('{1,0,0,0, 1,  0, 1, 0, 0});  // start from IDLE
        tbl.push_back('{0,0,0,0, 4,  1, 1, 0, 0});  // first tick 4 cycles in
        tbl.push_back('{0,0,0,0, 8,  3, 1, 0, 0});
        tbl.push_back('{0,0,0,0, 10, 5, 1, 0, 0});  // count 5 + 2 prescaler cycles
        tbl.push_back('{0,1,0,0, 1,  5, 0, 0, 0});  // stop
        tbl.push_back('{0,0,0,0, 10, 5, 0, 0, 0});  // paused, no change
        tbl.push_back('{1,0,0,0, 1,  5, 1, 0, 0});  // resume
        tbl.push_back('{0,0,0,0, 1,  5, 1, 0, 0});
        tbl.push_back('{0,0,0,0, 1,  6, 1, 0, 0});  // partial second resumed
        tbl.push_back('{0,0,0,0, 7,  7, 1, 0, 0});
        tbl.push_back('{0,0,0,1, 1,  8, 1, 7, 1});  // event on 7->8 increment
        tbl.push_back('{0,0,0,0, 8, 10, 1, 7, 1});
        tbl.push_back('{0,0,0,1, 1, 10, 1, 7, 1});  // second event ignored
        tbl.push_back('{0,0,1,0, 1,  0, 0, 0, 0});  // clear
        tbl.push_back('{1,0,0,0, 1,  0, 1, 0, 0});
        tbl.push_back('{0,0,0,0, 5,  1, 1, 0, 0});
        tbl.push_back('{1,1,1,0, 1,  0, 0, 0, 0});  // all three: clear wins
        tbl.push_back('{0,0,0,0, 3,  0, 0, 0, 0});
        tbl.push_back('{1,0,0,0, 1,  0, 1, 0, 0});
        tbl.push_back('{0,0,0,0, 2,  0, 1, 0, 0});
        tbl.push_back('{0,1,0,0, 1,  0, 0, 0, 0});  // pause with prescaler at 2
        tbl.push_back('{0,0,0,0, 1,  0, 0, 0, 0});
        tbl.push_back('{1,1,0,0, 1,  0, 0, 0, 0});  // start+stop in PAUSED: stays
        tbl.push_back('{0,0,0,0, 5,  0, 0, 0, 0});
        tbl.push_back('{1,0,0,0, 1,  0, 1, 0, 0});
        tbl.push_back('{0,0,0,0, 2,  1, 1, 0, 0});  // prescaler was preserved
        tbl.push_back('{0,0,1,0, 1,  0, 0, 0, 0});
        tbl.push_back('{0,0,0,1, 1,  0, 0, 0, 0});  // event in IDLE ignored
        tbl.push_back('{0,0,0,0, 1,  0, 0, 0, 0});

        foreach (tbl[i]) begin
            start = tbl[i].s; stop = tbl[i].p; clear = tbl[i].c; event_in = tbl[i].e;
            repeat (tbl[i].n) cyc();
            chk($sformatf("vec%0d.count", i),   cnt_b,          32'(tbl[i].cnt));
            chk($sformatf("vec%0d.running", i), 32'(run_b),     32'(tbl[i].run));
            chk($sformatf("vec%0d.evtime", i),  evt_b,          32'(tbl[i].et));
            chk($sformatf("vec%0d.evvalid", i), 32'(evv_b),     32'(tbl[i].ev));
        end

        // Wrap sequence on the 4-second instance
        start = 1'b0; stop = 1'b0; clear = 1'b0; event_in = 1'b0;
        resetn = 1'b0; cyc(); resetn = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk($sformatf("wrapseq%0d.count", k), cnt_w,       32'((k / 4) % 4));
            chk($sformatf("wrapseq%0d.wrap", k),  32'(wrap_w), 32'(k == 16));
            chk($sformatf("wrapseq%0d.tick", k),  32'(tick_w), 32'(k % 4 == 0));
        end

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            resetn   = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) start    = ~start;
            if ($urandom_range(0, 9) == 0) stop     = ~stop;
            if ($urandom_range(0, 39) == 0) clear   = ~clear;
            if ($urandom_range(0, 7) == 0) event_in = ~event_in;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
